// File: rtl/cpu_pkg.sv
// Shared widths and the EX/MEM bundle layout for the 16-bit pipelined RISC CPU.
package cpu_pkg;

    localparam int CPU_DATA_W     = 16;
    localparam int CPU_REG_ADDR_W = 4;
    localparam int CPU_MEM_ADDR_W = 4;

    // Field order matches the concatenation used by ex_mem_register.
    // The MEM stage and the forwarding unit can overlay this struct on the bundle.
    typedef struct packed {
        logic [CPU_DATA_W-1:0]     result;
        logic [CPU_REG_ADDR_W-1:0] reg_addr;
        logic [CPU_MEM_ADDR_W-1:0] mem_addr;
        logic                      write_en;
        logic                      store_en;
        logic                      load_en;
    } ex_mem_t;

    localparam int EX_MEM_W = $bits(ex_mem_t);

endpackage

// File: rtl/pipe_reg.sv
// Generic width-parameterized pipeline register.
// Async active-low reset. A synchronous clear wins over hold, and hold wins over capture.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear, hold or capture the whole word together so no field can update on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline boundary register.
// Every field travels in a single pipe_reg bundle. A flush loads an all-zero bubble,
// a stall holds the bundle, and otherwise the inputs are captured with one cycle of latency.
module ex_mem_register
    import cpu_pkg::*;
#(
    parameter int DATA_W     = CPU_DATA_W,
    parameter int REG_ADDR_W = CPU_REG_ADDR_W,
    parameter int MEM_ADDR_W = CPU_MEM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     result_in,
    input  logic [REG_ADDR_W-1:0] reg_addr_in,
    input  logic [MEM_ADDR_W-1:0] mem_addr_in,
    input  logic                  write_enable_in,
    input  logic                  store_enable_in,
    input  logic                  load_enable_in,
    output logic [DATA_W-1:0]     result_out,
    output logic [REG_ADDR_W-1:0] reg_addr_out,
    output logic [MEM_ADDR_W-1:0] mem_addr_out,
    output logic                  write_enable_out,
    output logic                  store_enable_out,
    output logic                  load_enable_out
);

    localparam int BUNDLE_W = DATA_W + REG_ADDR_W + MEM_ADDR_W + 3;

    logic [BUNDLE_W-1:0] d_bundle;
    logic [BUNDLE_W-1:0] q_bundle;

    // The control bits are forwarded as-is; legality of combinations belongs to decode.
    assign d_bundle = {result_in, reg_addr_in, mem_addr_in,
                       write_enable_in, store_enable_in, load_enable_in};

    assign {result_out, reg_addr_out, mem_addr_out,
            write_enable_out, store_enable_out, load_enable_out} = q_bundle;

    // Flush is wired to the clear, so a bubble takes priority over a stall.
    pipe_reg #(
        .W(BUNDLE_W)
    ) u_bundle_reg (
        .clk   (clk),
        .rst_n (reset),
        .en    (~stall),
        .clr   (flush),
        .d     (d_bundle),
        .q     (q_bundle)
    );

endmodule

// File: tb/tb_ex_mem_register.sv
// Bench for ex_mem_register: directed scenarios followed by a randomized run,
// checked against a cycle-level reference model of the pipeline register.
module tb_ex_mem_register;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [15:0] result_in;
    logic [3:0]  reg_addr_in;
    logic [3:0]  mem_addr_in;
    logic        write_enable_in;
    logic        store_enable_in;
    logic        load_enable_in;
    logic [15:0] result_out;
    logic [3:0]  reg_addr_out;
    logic [3:0]  mem_addr_out;
    logic        write_enable_out;
    logic        store_enable_out;
    logic        load_enable_out;

    int total = 0;
    int bad   = 0;

    // Reference model state: the word the MEM stage should currently see.
    logic [26:0] exp_word;
    logic [26:0] obs_word;

    ex_mem_register dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .result_in        (result_in),
        .reg_addr_in      (reg_addr_in),
        .mem_addr_in      (mem_addr_in),
        .write_enable_in  (write_enable_in),
        .store_enable_in  (store_enable_in),
        .load_enable_in   (load_enable_in),
        .result_out       (result_out),
        .reg_addr_out     (reg_addr_out),
        .mem_addr_out     (mem_addr_out),
        .write_enable_out (write_enable_out),
        .store_enable_out (store_enable_out),
        .load_enable_out  (load_enable_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs_word = {result_out, reg_addr_out, mem_addr_out,
                       write_enable_out, store_enable_out, load_enable_out};

    task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %07h want %07h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] r, input logic [3:0] ra, input logic [3:0] ma,
                         input logic we, input logic st, input logic ld);
        result_in       = r;
        reg_addr_in     = ra;
        mem_addr_in     = ma;
        write_enable_in = we;
        store_enable_in = st;
        load_enable_in  = ld;
    endtask

    // One rising edge: apply the rules (reset, then flush, then stall, else capture)
    // to the inputs present at the edge, then compare just after it.
    task automatic step(input string tag);
        logic [26:0] in_word;
        @(posedge clk);
        in_word = {result_in, reg_addr_in, mem_addr_in,
                   write_enable_in, store_enable_in, load_enable_in};
        if (!reset)      exp_word = '0;
        else if (flush)  exp_word = '0;
        else if (!stall) exp_word = in_word;
        #1;
        check(tag, obs_word, exp_word);
    endtask

    initial begin
        exp_word = '0;
        stall = 1'b0;
        flush = 1'b0;
        reset = 1'b0;
        drive(16'hBEEF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1);

        // Reset clears outputs before any clock edge and keeps them clear.
        #2;
        check("rst_async", obs_word, 27'd0);
        step("rst_edge1");
        step("rst_edge2");

        // Capture and stability across two further edges.
        @(negedge clk);
        reset = 1'b1;
        drive(16'h00AB, 4'b1010, 4'b1110, 1'b1, 1'b1, 1'b0);
        step("capture");
        check("capture_val", obs_word, {16'h00AB, 4'b1010, 4'b1110, 3'b110});
        step("capture_hold1");
        step("capture_hold2");

        // New inputs are not visible until the next edge.
        @(negedge clk);
        drive(16'h00FF, 4'b1001, 4'b0110, 1'b0, 1'b0, 1'b1);
        #1;
        check("update_pre", obs_word, {16'h00AB, 4'b1010, 4'b1110, 3'b110});
        step("update");
        check("update_val", obs_word, {16'h00FF, 4'b1001, 4'b0110, 3'b001});

        // Stall holds the old word for three edges, then the pending input appears.
        @(negedge clk);
        drive(16'h00AB, 4'b1010, 4'b1110, 1'b1, 1'b1, 1'b0);
        step("stall_load");
        @(negedge clk);
        stall = 1'b1;
        drive(16'h1234, 4'h3, 4'h5, 1'b0, 1'b1, 1'b1);
        step("stall1");
        step("stall2");
        step("stall3");
        check("stall_val", obs_word, {16'h00AB, 4'b1010, 4'b1110, 3'b110});
        @(negedge clk);
        stall = 1'b0;
        step("stall_release");
        check("stall_release_val", obs_word, {16'h1234, 4'h3, 4'h5, 3'b011});

        // Flush wins over stall.
        @(negedge clk);
        stall = 1'b1;
        flush = 1'b1;
        drive(16'h5A5A, 4'h7, 4'h9, 1'b1, 1'b0, 1'b1);
        step("flush_stall");
        check("flush_zero", obs_word, 27'd0);
        step("flush_hold");
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;

        // Mid-run reset pulse between edges clears at once; next edge captures.
        drive(16'h00FF, 4'b1001, 4'b0110, 1'b0, 1'b0, 1'b1);
        step("midrst_load");
        @(negedge clk);
        drive(16'hC0DE, 4'h2, 4'h4, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        exp_word = '0;
        check("midrst_async", obs_word, 27'd0);
        #2;
        reset = 1'b1;
        step("midrst_capture");
        check("midrst_val", obs_word, {16'hC0DE, 4'h2, 4'h4, 3'b100});

        // Randomized run with occasional stalls, flushes and async reset pulses.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive(16'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 31) == 0) begin
                reset = 1'b0;
                #1;
                exp_word = '0;
                check("rand_rst", obs_word, exp_word);
                #2;
                reset = 1'b1;
            end
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
